// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM cache arbiter.
// The watchdog constant applies only to builds with SDRAM_ARB_TIMEOUT_EN defined.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RDBURST,
        WRITE,
        TURN
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_C0,
        GNT_C1,
        GNT_WR
    } arb_grant_e;

    localparam int unsigned DEFAULT_BURSTLEN = 8;
    localparam logic [11:0] TIMEOUT_MAX      = 12'hFFF;

endpackage

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin picker between the cache fill requests.
// Combinational; the owner of last_grant_i updates it on each read grant.
module sdram_arb_rr (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        grant_o = 1'b0;
        case (req_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = ~last_grant_i;
            default: grant_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/sdram_cache_arbiter.sv
// Arbitrates one SDRAM controller port between two cache fill ports and a write-through port.
// Optional watchdog (timeout_err port) enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_cache_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned BURSTLEN = DEFAULT_BURSTLEN,
    parameter int unsigned ADDRW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c0_req,
    input  logic [ADDRW-1:0] c0_addr,
    output logic             c0_fill,
    input  logic             c1_req,
    input  logic [ADDRW-1:0] c1_addr,
    output logic             c1_fill,
    output logic [31:0]      fill_data,
    input  logic             wr_req,
    input  logic [ADDRW-1:0] wr_addr,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_bytesel,
    output logic             wr_ack,
    output logic             sd_req,
    output logic [ADDRW-1:0] sd_addr,
    output logic             sd_rw,
    output logic [31:0]      sd_wdata,
    output logic [3:0]       sd_bytesel,
    input  logic             sd_ack,
    input  logic             sd_fill,
    input  logic [31:0]      sd_rdata,
`ifdef SDRAM_ARB_TIMEOUT_EN
    output logic             timeout_err,
`endif
    output logic             busy
);

    localparam int unsigned BEATW = $clog2(BURSTLEN);

    arb_state_e       state_q, state_d;
    arb_grant_e       grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [BEATW-1:0] beat_q, beat_d;
    logic             sd_req_q, sd_req_d;
    logic             sd_rw_q, sd_rw_d;
    logic [ADDRW-1:0] sd_addr_q, sd_addr_d;
    logic [31:0]      sd_wdata_q, sd_wdata_d;
    logic [3:0]       sd_bytesel_q, sd_bytesel_d;
    logic             wr_ack_q, wr_ack_d;
    logic             rr_grant;
    logic             rr_valid;

`ifdef SDRAM_ARB_TIMEOUT_EN
    logic [11:0]      wdog_q, wdog_d;
    logic             tmo_q, tmo_d;
`endif

    sdram_arb_rr u_rr (
        .req_i        ({c1_req, c0_req}),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant),
        .valid_o      (rr_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= GNT_C0;
            last_grant_q <= 1'b1;
            beat_q       <= '0;
            sd_req_q     <= 1'b0;
            sd_rw_q      <= 1'b1;
            sd_addr_q    <= '0;
            sd_wdata_q   <= '0;
            sd_bytesel_q <= '0;
            wr_ack_q     <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            wdog_q       <= '0;
            tmo_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            sd_req_q     <= sd_req_d;
            sd_rw_q      <= sd_rw_d;
            sd_addr_q    <= sd_addr_d;
            sd_wdata_q   <= sd_wdata_d;
            sd_bytesel_q <= sd_bytesel_d;
            wr_ack_q     <= wr_ack_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
            wdog_q       <= wdog_d;
            tmo_q        <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        sd_req_d     = sd_req_q;
        sd_rw_d      = sd_rw_q;
        sd_addr_d    = sd_addr_q;
        sd_wdata_d   = sd_wdata_q;
        sd_bytesel_d = sd_bytesel_q;
        wr_ack_d     = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
        wdog_d       = '0;
        tmo_d        = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // Writes win so a later fill of the same line sees the new data.
                if (wr_req) begin
                    grant_d      = GNT_WR;
                    sd_addr_d    = wr_addr;
                    sd_wdata_d   = wr_data;
                    sd_bytesel_d = wr_bytesel;
                    sd_rw_d      = 1'b0;
                    sd_req_d     = 1'b1;
                    state_d      = WRITE;
                end else if (rr_valid) begin
                    grant_d      = rr_grant ? GNT_C1 : GNT_C0;
                    last_grant_d = rr_grant;
                    sd_addr_d    = rr_grant ? c1_addr : c0_addr;
                    sd_bytesel_d = '1;
                    sd_rw_d      = 1'b1;
                    sd_req_d     = 1'b1;
                    state_d      = RDBURST;
                end
            end
            RDBURST: begin
                if (sd_fill) begin
                    sd_req_d = 1'b0;
                    if (beat_q == BEATW'(BURSTLEN - 1)) begin
                        beat_d  = '0;
                        state_d = TURN;
                    end else begin
                        beat_d = beat_q + BEATW'(1);
                    end
                end
            end
            WRITE: begin
                if (sd_ack) begin
                    sd_req_d = 1'b0;
                    wr_ack_d = 1'b1;
                    state_d  = TURN;
                end
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef SDRAM_ARB_TIMEOUT_EN
        if ((state_q == RDBURST) || (state_q == WRITE)) begin
            if (((state_q == RDBURST) && sd_fill) || ((state_q == WRITE) && sd_ack)) begin
                wdog_d = '0;
            end else if (wdog_q == TIMEOUT_MAX) begin
                tmo_d    = 1'b1;
                sd_req_d = 1'b0;
                beat_d   = '0;
                state_d  = TURN;
            end else begin
                wdog_d = wdog_q + 12'd1;
            end
        end
`endif
    end

    // Fill strobes are combinational so the cache captures data in its arrival cycle.
    assign c0_fill    = sd_fill & (state_q == RDBURST) & (grant_q == GNT_C0);
    assign c1_fill    = sd_fill & (state_q == RDBURST) & (grant_q == GNT_C1);
    assign fill_data  = sd_rdata;
    assign wr_ack     = wr_ack_q;
    assign sd_req     = sd_req_q;
    assign sd_addr    = sd_addr_q;
    assign sd_rw      = sd_rw_q;
    assign sd_wdata   = sd_wdata_q;
    assign sd_bytesel = sd_bytesel_q;
    assign busy       = (state_q != IDLE);
`ifdef SDRAM_ARB_TIMEOUT_EN
    assign timeout_err = tmo_q;
`endif

endmodule
